// File: rtl/pmp_seq_checker_pkg.sv
// Shared types for the sequential PMP checker: pmpcfg layout, address-matching modes,
// access types and checker FSM states.
package pmp_seq_checker_pkg;

  localparam int unsigned MAX_ENTRIES = 16;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } pmp_mode_e;

  typedef struct packed {
    logic      l;
    logic [1:0] rsv;
    pmp_mode_e a;
    logic      x;
    logic      w;
    logic      r;
  } pmpcfg_t;

  typedef enum logic [1:0] {
    ACC_R = 2'd0,
    ACC_W = 2'd1,
    ACC_X = 2'd2
  } access_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } chk_state_e;

  // Permission bit selected by the access type; the reserved encoding grants nothing.
  function automatic logic acc_perm(input pmpcfg_t cfg, input logic [1:0] acc);
    logic perm;
    case (acc)
      ACC_R:   perm = cfg.r;
      ACC_W:   perm = cfg.w;
      ACC_X:   perm = cfg.x;
      default: perm = 1'b0;
    endcase
    return perm;
  endfunction

endpackage

// File: rtl/pmp_seq_checker_entry_match.sv
// Combinational address match for a single PMP entry (OFF / TOR / NA4 / NAPOT).
// All address operands are word addresses (byte address >> 2).
module pmp_entry_match
  import pmp_seq_checker_pkg::*;
(
  input  pmpcfg_t     cfg,
  input  logic [31:0] addr,
  input  logic [31:0] prev_addr,
  input  logic [31:0] a,
  output logic        match
);

  logic [31:0] napot_mask_s;
  logic        unused_cfg_s;

  // Only the mode field takes part in matching; permissions are applied by the caller.
  assign unused_cfg_s = ^{cfg.l, cfg.rsv, cfg.x, cfg.w, cfg.r};

  // addr ^ (addr+1) sets exactly the trailing-ones run plus the bit above it,
  // so an all-ones pmpaddr yields an all-zero mask and matches everything.
  always_comb begin
    match        = 1'b0;
    napot_mask_s = ~(addr ^ (addr + 32'd1));
    case (cfg.a)
      PMP_TOR:   match = (a >= prev_addr) && (a < addr);
      PMP_NA4:   match = (a == addr);
      PMP_NAPOT: match = ((a & napot_mask_s) == (addr & napot_mask_s));
      default:   match = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP permission checker: scans one entry per cycle in priority order.
// Optional sticky first-fault capture when PMP_FAULT_LOG_EN is defined.
module pmp_seq_checker
  import pmp_seq_checker_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned XLEN        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ENTRIES*8-1:0] pmpcfg_i,
  input  logic [NUM_ENTRIES*32-1:0] pmpaddr_i,
  output logic                     cfg_busy_o,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [XLEN-1:0]          req_addr_i,
  input  logic [1:0]               req_acc_i,
  input  logic                     req_mmode_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_allow_o,
  output logic                     rsp_hit_o,
  output logic [3:0]               rsp_idx_o,
  output logic                     flt_valid_o,
  output logic [XLEN-1:0]          flt_addr_o,
  output logic [1:0]               flt_acc_o,
  input  logic                     flt_clr_i
);

  localparam int unsigned CFG_W    = MAX_ENTRIES * 8;
  localparam int unsigned ADDR_W   = MAX_ENTRIES * 32;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_ENTRIES - 1);

  chk_state_e       state_r, state_next_s;
  logic [3:0]       idx_r, idx_next_s, idx_prev_s;
  logic [XLEN-1:0]  addr_r;
  logic [1:0]       acc_r;
  logic             mmode_r;
  logic             req_ready_r, cfg_busy_r;
  logic             rsp_valid_r, rsp_allow_r, rsp_hit_r;
  logic [3:0]       rsp_idx_r;

  logic [CFG_W-1:0]  cfg_pad_s;
  logic [ADDR_W-1:0] addr_pad_s;
  pmpcfg_t           cur_cfg_s;
  logic [31:0]       cur_addr_s, prev_addr_s, a_s;
  logic              match_s, finish_s;
  logic              res_allow_s, res_hit_s;
  logic [3:0]        res_idx_s;

  // Select the entry under scan; the previous entry supplies the TOR lower bound.
  always_comb begin
    cfg_pad_s   = CFG_W'(pmpcfg_i);
    addr_pad_s  = ADDR_W'(pmpaddr_i);
    idx_prev_s  = idx_r - 4'd1;
    cur_cfg_s   = pmpcfg_t'(cfg_pad_s[{idx_r, 3'b000} +: 8]);
    cur_addr_s  = addr_pad_s[{idx_r, 5'b00000} +: 32];
    a_s         = 32'({2'b00, addr_r[XLEN-1:2]});
    if (idx_r == 4'd0) begin
      prev_addr_s = 32'd0;
    end else begin
      prev_addr_s = addr_pad_s[{idx_prev_s, 5'b00000} +: 32];
    end
  end

  pmp_entry_match u_match (
    .cfg       (cur_cfg_s),
    .addr      (cur_addr_s),
    .prev_addr (prev_addr_s),
    .a         (a_s),
    .match     (match_s)
  );

  // Result of the current scan step: matched entry or the no-hit default.
  always_comb begin
    res_hit_s   = 1'b0;
    res_idx_s   = 4'd0;
    res_allow_s = 1'b0;
    if (match_s) begin
      res_hit_s   = 1'b1;
      res_idx_s   = idx_r;
      res_allow_s = (acc_r != 2'd3) & (acc_perm(cur_cfg_s, acc_r) | (mmode_r & ~cur_cfg_s.l));
    end else begin
      res_hit_s   = 1'b0;
      res_idx_s   = 4'd0;
      res_allow_s = (acc_r != 2'd3) & mmode_r;
    end
    finish_s = (state_r == SCAN) && (match_s || (idx_r == LAST_IDX));
  end

  // Next-state and scan index.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i) begin
          state_next_s = SCAN;
          idx_next_s   = 4'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (finish_s) begin
          state_next_s = RESP;
        end else begin
          idx_next_s = idx_r + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
        idx_next_s   = 4'd0;
      end
    endcase
  end

  // State register plus handshake flags decoded one cycle early so they leave as flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= 4'd0;
      req_ready_r <= 1'b1;
      cfg_busy_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      idx_r       <= idx_next_s;
      req_ready_r <= (state_next_s == IDLE);
      cfg_busy_r  <= (state_next_s == SCAN);
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= '0;
      acc_r   <= 2'd0;
      mmode_r <= 1'b0;
    end else if ((state_r == IDLE) && req_valid_i) begin
      addr_r  <= req_addr_i;
      acc_r   <= req_acc_i;
      mmode_r <= req_mmode_i;
    end
  end

  // Response registers: loaded when the scan resolves, held until the consumer takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_allow_r <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_idx_r   <= 4'd0;
    end else if (finish_s) begin
      rsp_valid_r <= 1'b1;
      rsp_allow_r <= res_allow_s;
      rsp_hit_r   <= res_hit_s;
      rsp_idx_r   <= res_idx_s;
    end else if ((state_r == RESP) && rsp_ready_i) begin
      rsp_valid_r <= 1'b0;
      rsp_allow_r <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_idx_r   <= 4'd0;
    end
  end

  assign req_ready_o = req_ready_r;
  assign cfg_busy_o  = cfg_busy_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_allow_o = rsp_allow_r;
  assign rsp_hit_o   = rsp_hit_r;
  assign rsp_idx_o   = rsp_idx_r;

`ifdef PMP_FAULT_LOG_EN
  logic            flt_valid_r;
  logic [XLEN-1:0] flt_addr_r;
  logic [1:0]      flt_acc_r;

  // First denied access wins; a capture in the same cycle beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_valid_r <= 1'b0;
      flt_addr_r  <= '0;
      flt_acc_r   <= 2'd0;
    end else if (finish_s && !res_allow_s && !flt_valid_r) begin
      flt_valid_r <= 1'b1;
      flt_addr_r  <= addr_r;
      flt_acc_r   <= acc_r;
    end else if (flt_clr_i) begin
      flt_valid_r <= 1'b0;
    end
  end

  assign flt_valid_o = flt_valid_r;
  assign flt_addr_o  = flt_addr_r;
  assign flt_acc_o   = flt_acc_r;
`else
  logic unused_flt_s;

  assign unused_flt_s = ^{flt_clr_i, addr_r[1:0]};
  assign flt_valid_o  = 1'b0;
  assign flt_addr_o   = '0;
  assign flt_acc_o    = 2'd0;
`endif

endmodule
